// File: rtl/regfile_sb.sv
// Two-read/one-write register file with registered read ports, optional write bypass,
// and a per-register pending scoreboard for read-after-write hazard detection.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            hazard
);

  localparam logic [AW:0] NregsW = (AW+1)'(NREGS);
  localparam logic        Byp    = (BYPASS != 0);
  localparam logic        Zr     = (ZERO_REG != 0);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [XLEN-1:0]  op1, op2;
  logic             fwd1, fwd2;

  // Address names a real, writable register (not out of range, not hardwired zero).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NregsW) && !(Zr && (a == '0));
  endfunction

  assign fwd1 = Byp && wr_en && (wr_addr == rs1_addr);
  assign fwd2 = Byp && wr_en && (wr_addr == rs2_addr);

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (addr_ok(rs1_addr)) op1 = fwd1 ? wr_data : regs_q[rs1_addr];
    if (addr_ok(rs2_addr)) op2 = fwd2 ? wr_data : regs_q[rs2_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en && addr_ok(wr_addr)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_data <= '0;
      rs2_data <= '0;
    end else if (rd_en) begin
      rs1_data <= op1;
      rs2_data <= op2;
    end
  end

  // Set is applied after clear so a newer issue wins over a same-cycle writeback.
  always_comb begin
    pend_d = pend_q;
    if (wr_en && addr_ok(wr_addr))   pend_d[wr_addr]  = 1'b0;
    if (iss_en && addr_ok(iss_addr)) pend_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_d;
  end

  assign rs1_busy = addr_ok(rs1_addr) && pend_q[rs1_addr] && !fwd1;
  assign rs2_busy = addr_ok(rs2_addr) && pend_q[rs2_addr] && !fwd2;
  assign hazard   = rd_en && (rs1_busy || rs2_busy);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: read results are queued when a read is driven and
// compared one cycle later; busy/hazard flags are checked combinationally.
module tb_regfile_sb;

  logic        clk, rst;
  logic        rd_en, wr_en, iss_en;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_addr;
  logic [31:0] wr_data, rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy, hazard;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t        expq[$];
  exp_t        e;
  logic [31:0] last1, last2;
  int          checks = 0;
  int          errors = 0;

  regfile_sb #(
    .XLEN    (32),
    .NREGS   (32),
    .AW      (5),
    .ZERO_REG(1),
    .BYPASS  (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy),
    .hazard  (hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia);
    rd_en = rd; rs1_addr = a1; rs2_addr = a2;
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
    if (rd) expq.push_back('0);
  endtask

  // Overwrite the zero entry queued by drive() with the expected operands.
  task automatic expect_rd(input logic [31:0] d1, input logic [31:0] d2);
    e.d1 = d1;
    e.d2 = d2;
    void'(expq.pop_back());
    expq.push_back(e);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      last1 = e.d1;
      last2 = e.d2;
    end
    chk({tag, ".rs1"}, rs1_data, last1);
    chk({tag, ".rs2"}, rs2_data, last2);
  endtask

  initial begin
    rst = 1'b0;
    last1 = '0;
    last2 = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rs1", rs1_data, 0);
    chk("rst.rs2", rs2_data, 0);
    rst = 1'b1;
    #1;

    drive(1, 3, 0, 0, 0, 0, 0, 0);
    expect_rd(0, 0);
    #1;
    chk("init.busy1", {31'b0, rs1_busy}, 0);
    chk("init.busy2", {31'b0, rs2_busy}, 0);
    chk("init.hazard", {31'b0, hazard}, 0);
    tick("rd_r3_r0");

    drive(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    tick("wr_r5_hold");
    drive(1, 5, 0, 0, 0, 0, 0, 0);
    expect_rd(32'hDEADBEEF, 0);
    tick("rd_r5");

    drive(0, 0, 0, 1, 0, 32'h1234, 0, 0);
    tick("wr_r0_hold");
    drive(1, 0, 5, 0, 0, 0, 0, 0);
    expect_rd(0, 32'hDEADBEEF);
    tick("rd_r0_r5");

    drive(1, 5, 7, 1, 7, 32'hA5A5A5A5, 0, 0);
    expect_rd(32'hDEADBEEF, 32'hA5A5A5A5);
    tick("bypass_r7");
    drive(1, 7, 7, 0, 0, 0, 0, 0);
    expect_rd(32'hA5A5A5A5, 32'hA5A5A5A5);
    tick("rd_r7");

    drive(0, 7, 7, 0, 0, 0, 1, 9);
    tick("iss_r9_hold");
    drive(1, 9, 0, 0, 0, 0, 0, 0);
    expect_rd(0, 0);
    #1;
    chk("r9.busy1", {31'b0, rs1_busy}, 1);
    chk("r9.busy2", {31'b0, rs2_busy}, 0);
    chk("r9.hazard", {31'b0, hazard}, 1);
    tick("rd_r9_pending");

    drive(1, 9, 0, 1, 9, 32'h99, 0, 0);
    expect_rd(32'h99, 0);
    #1;
    chk("r9wb.busy1", {31'b0, rs1_busy}, 0);
    chk("r9wb.hazard", {31'b0, hazard}, 0);
    tick("rd_r9_bypass");
    drive(0, 9, 0, 0, 0, 0, 0, 0);
    #1;
    chk("r9done.busy1", {31'b0, rs1_busy}, 0);
    tick("r9_hold");

    drive(0, 9, 0, 1, 4, 32'h44, 1, 4);
    tick("iss_wr_r4");
    drive(1, 9, 4, 0, 0, 0, 0, 0);
    expect_rd(32'h99, 32'h44);
    #1;
    chk("r4.busy2", {31'b0, rs2_busy}, 1);
    chk("r4.hazard", {31'b0, hazard}, 1);
    tick("rd_r9_r4");

    drive(0, 0, 0, 0, 0, 0, 1, 0);
    tick("iss_r0");
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    expect_rd(0, 0);
    #1;
    chk("r0.busy1", {31'b0, rs1_busy}, 0);
    chk("r0.hazard", {31'b0, hazard}, 0);
    tick("rd_r0");

    drive(0, 0, 0, 1, 2, 32'h55, 1, 2);
    tick("wr_iss_r2");
    drive(1, 2, 2, 0, 0, 0, 0, 0);
    expect_rd(32'h55, 32'h55);
    #1;
    chk("r2.busy1", {31'b0, rs1_busy}, 1);
    tick("rd_r2");

    drive(0, 2, 2, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst.rs1", rs1_data, 0);
    chk("midrst.rs2", rs2_data, 0);
    chk("midrst.busy1", {31'b0, rs1_busy}, 0);
    chk("midrst.busy2", {31'b0, rs2_busy}, 0);
    last1 = '0;
    last2 = '0;
    #1;
    rst = 1'b1;
    drive(1, 2, 4, 0, 0, 0, 0, 0);
    expect_rd(0, 0);
    #1;
    chk("post.busy2", {31'b0, rs2_busy}, 0);
    tick("rd_r2_r4_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
